// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the LM75 temperature display path.
package display_pkg;

  // Width of one BCD digit.
  localparam int NIBBLE_W = 4;

  // Digit code that the segment decoder renders with every segment off.
  localparam logic [4:0] BLANK_CODE = 5'd31;

  // Digit positions as seen by the decoder (position 2 carries the DP).
  localparam logic [3:0] POS_TENTHS   = 4'd1;
  localparam logic [3:0] POS_UNITS    = 4'd2;
  localparam logic [3:0] POS_TENS     = 4'd3;
  localparam logic [3:0] POS_HUNDREDS = 4'd4;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  // Absolute value of a 9-bit two's-complement temperature sample.
  // -256 (9'h100) maps onto itself, which reads back as 256 unsigned.
  function automatic logic [8:0] magnitude(input logic [8:0] temp);
    return temp[8] ? (~temp + 9'd1) : temp;
  endfunction

endpackage

// File: rtl/lm75_display_scanner_if.sv
// Bus between the temperature source/decoder side and the display scanner.
interface lm75_display_scanner_if;
  logic [8:0] TEMP;
  logic       TEMP_VALID;
  logic [4:0] D;
  logic [3:0] DIGIT_POSN;
  logic [3:0] AN;
  logic       NEG;
  logic       BUSY;

  // Side that supplies temperatures and consumes digit codes.
  modport master (
    output TEMP, TEMP_VALID,
    input  D, DIGIT_POSN, AN, NEG, BUSY
  );

  // The scanner itself.
  modport slave (
    input  TEMP, TEMP_VALID,
    output D, DIGIT_POSN, AN, NEG, BUSY
  );
endinterface

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// A start pulse loads the operand; the next eight edges each perform one
// add-3/shift step. done is high during the cycle whose closing edge does
// the final step, so the BCD outputs are valid right after that edge.
module bin2bcd8
  import display_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          bin,
  output logic                done,
  output logic [NIBBLE_W-1:0] hundreds,
  output logic [NIBBLE_W-1:0] tens,
  output logic [NIBBLE_W-1:0] units
);

  localparam int BCD_W = 3 * NIBBLE_W;
  localparam int SR_W  = BCD_W + 8;

  // {hundreds, tens, units, remaining binary bits}
  logic [SR_W-1:0] shreg;
  logic [SR_W-1:0] adjusted;
  logic [3:0]      count;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  // NOTE: always_comb gives every output a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    adjusted = shreg;
    for (int i = 0; i < 3; i++) begin
      if (shreg[8 + i*NIBBLE_W +: NIBBLE_W] >= 4'd5)
        adjusted[8 + i*NIBBLE_W +: NIBBLE_W] = shreg[8 + i*NIBBLE_W +: NIBBLE_W] + 4'd3;
    end
  end

  // Load on start, otherwise one adjust-and-shift step per edge while count is non-zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else if (start) begin
      shreg <= {{BCD_W{1'b0}}, bin};
      count <= 4'd8;
    end else if (count != 4'd0) begin
      shreg <= {adjusted[SR_W-2:0], 1'b0};
      count <= count - 4'd1;
    end
  end

  assign done     = (count == 4'd1);
  assign hundreds = shreg[8 + 2*NIBBLE_W +: NIBBLE_W];
  assign tens     = shreg[8 + 1*NIBBLE_W +: NIBBLE_W];
  assign units    = shreg[8 +: NIBBLE_W];

endmodule

// File: rtl/lm75_display_scanner.sv
// LM75 temperature to 4-digit multiplexed display source.
// Converts a 9-bit half-degree sample to BCD, applies leading-zero blanking,
// keeps a one-deep pending sample, and scans the four digits with anodes
// delayed one cycle to line up with the decoder's registered segments.
module lm75_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic [4:0]  BLANK_CODE  = display_pkg::BLANK_CODE
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  lm75_display_scanner_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  state_t              state;
  logic                busy;
  logic                pend_valid;
  logic [8:0]          pend_temp;
  logic                sign_r;
  logic                half_r;
  logic                neg;

  logic                conv_start;
  logic [8:0]          src_temp;
  logic [8:0]          src_mag;
  logic [7:0]          conv_bin;
  logic                conv_done;
  logic [NIBBLE_W-1:0] bcd_h;
  logic [NIBBLE_W-1:0] bcd_t;
  logic [NIBBLE_W-1:0] bcd_u;

  logic [4:0]          disp_tenths;
  logic [4:0]          disp_units;
  logic [4:0]          disp_tens;
  logic [4:0]          disp_hundreds;

  logic [CNT_W-1:0]    refresh_cnt;
  logic [3:0]          posn;
  logic [3:0]          next_posn;
  logic [4:0]          next_code;
  logic [4:0]          d;
  logic [3:0]          an;

  // Pick the sample that starts the next conversion: a fresh strobe in IDLE
  // (newest wins over a leftover pending one), or the pending sample at COMMIT.
  always_comb begin
    src_temp   = bus.TEMP;
    conv_start = 1'b0;
    case (state)
      IDLE: begin
        conv_start = bus.TEMP_VALID || pend_valid;
        if (!bus.TEMP_VALID) src_temp = pend_temp;
      end
      COMMIT: begin
        conv_start = pend_valid;
        src_temp   = pend_temp;
      end
      default: ;
    endcase
    src_mag  = magnitude(src_temp);
    conv_bin = src_mag[8:1];
  end

  bin2bcd8 u_bin2bcd8 (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start    (conv_start),
    .bin      (conv_bin),
    .done     (conv_done),
    .hundreds (bcd_h),
    .tens     (bcd_t),
    .units    (bcd_u)
  );

  // Conversion sequencer: capture sample, wait for the BCD result, commit with blanking.
  // NOTE: the display registers are a handful of flops, not a RAM, so they reset to blank with the rest.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= IDLE;
      busy          <= 1'b0;
      pend_valid    <= 1'b0;
      pend_temp     <= '0;
      sign_r        <= 1'b0;
      half_r        <= 1'b0;
      neg           <= 1'b0;
      disp_tenths   <= BLANK_CODE;
      disp_units    <= BLANK_CODE;
      disp_tens     <= BLANK_CODE;
      disp_hundreds <= BLANK_CODE;
    end else begin
      case (state)
        IDLE: begin
          if (conv_start) begin
            sign_r     <= src_temp[8];
            half_r     <= src_mag[0];
            pend_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.TEMP_VALID) begin
            pend_temp  <= bus.TEMP;
            pend_valid <= 1'b1;
          end
          if (conv_done) state <= COMMIT;
        end
        COMMIT: begin
          disp_hundreds <= (bcd_h == '0) ? BLANK_CODE : 5'(bcd_h);
          disp_tens     <= (bcd_h == '0 && bcd_t == '0) ? BLANK_CODE : 5'(bcd_t);
          disp_units    <= 5'(bcd_u);
          disp_tenths   <= half_r ? 5'd5 : 5'd0;
          neg           <= sign_r;
          // A strobe on this edge becomes the new pending sample either way.
          pend_valid    <= bus.TEMP_VALID;
          if (bus.TEMP_VALID) pend_temp <= bus.TEMP;
          if (pend_valid) begin
            sign_r <= src_temp[8];
            half_r <= src_mag[0];
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Next scan position and the code it shows.
  always_comb begin
    next_posn = (posn == POS_HUNDREDS) ? POS_TENTHS : posn + 4'd1;
    case (next_posn)
      POS_TENTHS:   next_code = disp_tenths;
      POS_UNITS:    next_code = disp_units;
      POS_TENS:     next_code = disp_tens;
      POS_HUNDREDS: next_code = disp_hundreds;
      default:      next_code = BLANK_CODE;
    endcase
  end

  // Refresh divider, digit mux, and one-cycle-late anode drive.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      refresh_cnt <= '0;
      posn        <= POS_TENTHS;
      d           <= BLANK_CODE;
      an          <= 4'b1111;
    end else begin
      an <= ~(4'b0001 << (posn - 4'd1));
      if (refresh_cnt == CNT_MAX) begin
        refresh_cnt <= '0;
        posn        <= next_posn;
        d           <= next_code;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  assign bus.D          = d;
  assign bus.DIGIT_POSN = posn;
  assign bus.AN         = an;
  assign bus.NEG        = neg;
  assign bus.BUSY       = busy;

endmodule
